// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared memory-bus types and arbiter constants
package mem_arbiter_pkg;

  localparam int NUM_MEM_TAGS = 15;

  typedef logic [3:0]  MEM_TAG;
  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  typedef enum logic {
    OWNER_ICACHE = 1'b0,
    OWNER_DCACHE = 1'b1
  } MEM_OWNER;

  localparam int ARB_STARVE_LIMIT    = 4;
  localparam int ARB_MAX_OUTSTANDING = NUM_MEM_TAGS;

  // Wide enough to count every non-zero tag in flight at once.
  localparam int OUTSTANDING_W = $clog2(NUM_MEM_TAGS + 1);

endpackage

// File: rtl/mem_tag_table.sv
// rtl/mem_tag_table.sv - tag ownership table for in-flight loads
module mem_tag_table
  import mem_arbiter_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     set_en,
  input  MEM_TAG                   set_tag,
  input  MEM_OWNER                 set_owner,
  input  MEM_TAG                   lookup_tag,
  output logic                     lookup_hit,
  output MEM_OWNER                 lookup_owner,
  output logic [OUTSTANDING_W-1:0] outstanding
);

  logic [NUM_MEM_TAGS:0]    valid_q, valid_d;
  logic [NUM_MEM_TAGS:0]    owner_q, owner_d;
  logic [OUTSTANDING_W-1:0] outstanding_q, outstanding_d;

  // Tag 0 means "no data" and is never recorded, so it can never hit.
  assign lookup_hit   = (lookup_tag != '0) && valid_q[lookup_tag];
  assign lookup_owner = MEM_OWNER'(owner_q[lookup_tag]);
  assign outstanding  = outstanding_q;

  always_comb begin
    valid_d       = valid_q;
    owner_d       = owner_q;
    outstanding_d = outstanding_q;
    if (lookup_hit) begin
      valid_d[lookup_tag] = 1'b0;
    end
    // Applied after the clear so a same-tag reissue keeps the new owner.
    if (set_en) begin
      valid_d[set_tag] = 1'b1;
      owner_d[set_tag] = set_owner;
    end
    if (set_en && !lookup_hit) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!set_en && lookup_hit) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q       <= '0;
      owner_q       <= '0;
      outstanding_q <= '0;
    end else begin
      valid_q       <= valid_d;
      owner_q       <= owner_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter onto one memory port
// Dcache has priority; a starved icache wins once, loads stall when all tags are in flight.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT    = ARB_STARVE_LIMIT,
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ic_req_valid,
  input  ADDR        ic_req_addr,
  output logic       ic_req_accepted,
  output MEM_TAG     ic_req_tag,
  input  logic       dc_req_valid,
  input  MEM_COMMAND dc_req_cmd,
  input  ADDR        dc_req_addr,
  input  MEM_BLOCK   dc_req_data,
  output logic       dc_req_accepted,
  output MEM_TAG     dc_req_tag,
  output MEM_COMMAND proc2mem_command,
  output ADDR        proc2mem_addr,
  output MEM_BLOCK   proc2mem_data,
  input  MEM_TAG     mem2proc_transaction_tag,
  input  MEM_TAG     mem2proc_data_tag,
  input  MEM_BLOCK   mem2proc_data,
  output logic       ic_return_valid,
  output logic       dc_return_valid,
  output MEM_TAG     return_tag,
  output MEM_BLOCK   return_data
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0]            starve_cnt_q, starve_cnt_d;
  logic [OUTSTANDING_W-1:0] outstanding;
  logic                     loads_blocked, ic_priority;
  logic                     dc_eligible, ic_eligible;
  logic                     grant_ic, grant_dc, mem_ok;
  logic                     set_en, lookup_hit;
  MEM_OWNER                 set_owner, lookup_owner;

  always_comb begin
    loads_blocked = (outstanding >= OUTSTANDING_W'(MAX_OUTSTANDING));
    ic_priority   = ic_req_valid && (starve_cnt_q == SW'(STARVE_LIMIT));
    // A blocked dcache load also blocks the icache, since it is a load too.
    dc_eligible   = dc_req_valid &&
                    ((dc_req_cmd == MEM_STORE) ||
                     ((dc_req_cmd == MEM_LOAD) && !loads_blocked));
    ic_eligible   = ic_req_valid && !loads_blocked;
    grant_ic      = !reset && ic_eligible && (ic_priority || !dc_eligible);
    grant_dc      = !reset && dc_eligible && !grant_ic;
    mem_ok        = (mem2proc_transaction_tag != '0);
  end

  always_comb begin
    proc2mem_command = MEM_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    if (grant_ic) begin
      proc2mem_command = MEM_LOAD;
      proc2mem_addr    = ic_req_addr;
    end else if (grant_dc) begin
      proc2mem_command = dc_req_cmd;
      proc2mem_addr    = dc_req_addr;
      if (dc_req_cmd == MEM_STORE) begin
        proc2mem_data = dc_req_data;
      end
    end
    ic_req_accepted = grant_ic && mem_ok;
    dc_req_accepted = grant_dc && mem_ok;
    ic_req_tag      = grant_ic ? mem2proc_transaction_tag : '0;
    dc_req_tag      = grant_dc ? mem2proc_transaction_tag : '0;
    set_en          = mem_ok && (grant_ic || (grant_dc && (dc_req_cmd == MEM_LOAD)));
    set_owner       = grant_ic ? OWNER_ICACHE : OWNER_DCACHE;
    ic_return_valid = !reset && lookup_hit && (lookup_owner == OWNER_ICACHE);
    dc_return_valid = !reset && lookup_hit && (lookup_owner == OWNER_DCACHE);
    return_tag      = mem2proc_data_tag;
    return_data     = mem2proc_data;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!ic_req_valid || ic_req_accepted) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SW'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  mem_tag_table u_table (
    .clock        (clock),
    .reset        (reset),
    .set_en       (set_en),
    .set_tag      (mem2proc_transaction_tag),
    .set_owner    (set_owner),
    .lookup_tag   (mem2proc_data_tag),
    .lookup_hit   (lookup_hit),
    .lookup_owner (lookup_owner),
    .outstanding  (outstanding)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic       clock;
  logic       reset;
  logic       ic_req_valid;
  ADDR        ic_req_addr;
  logic       ic_req_accepted;
  MEM_TAG     ic_req_tag;
  logic       dc_req_valid;
  MEM_COMMAND dc_req_cmd;
  ADDR        dc_req_addr;
  MEM_BLOCK   dc_req_data;
  logic       dc_req_accepted;
  MEM_TAG     dc_req_tag;
  MEM_COMMAND proc2mem_command;
  ADDR        proc2mem_addr;
  MEM_BLOCK   proc2mem_data;
  MEM_TAG     mem2proc_transaction_tag;
  MEM_TAG     mem2proc_data_tag;
  MEM_BLOCK   mem2proc_data;
  logic       ic_return_valid;
  logic       dc_return_valid;
  MEM_TAG     return_tag;
  MEM_BLOCK   return_data;

  int passed;
  int total;

  mem_arbiter dut (
    .clock                    (clock),
    .reset                    (reset),
    .ic_req_valid             (ic_req_valid),
    .ic_req_addr              (ic_req_addr),
    .ic_req_accepted          (ic_req_accepted),
    .ic_req_tag               (ic_req_tag),
    .dc_req_valid             (dc_req_valid),
    .dc_req_cmd               (dc_req_cmd),
    .dc_req_addr              (dc_req_addr),
    .dc_req_data              (dc_req_data),
    .dc_req_accepted          (dc_req_accepted),
    .dc_req_tag               (dc_req_tag),
    .proc2mem_command         (proc2mem_command),
    .proc2mem_addr            (proc2mem_addr),
    .proc2mem_data            (proc2mem_data),
    .mem2proc_transaction_tag (mem2proc_transaction_tag),
    .mem2proc_data_tag        (mem2proc_data_tag),
    .mem2proc_data            (mem2proc_data),
    .ic_return_valid          (ic_return_valid),
    .dc_return_valid          (dc_return_valid),
    .return_tag               (return_tag),
    .return_data              (return_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ic_req_valid             = 1'b0;
    ic_req_addr              = '0;
    dc_req_valid             = 1'b0;
    dc_req_cmd               = MEM_NONE;
    dc_req_addr              = '0;
    dc_req_data              = '0;
    mem2proc_transaction_tag = '0;
    mem2proc_data_tag        = '0;
    mem2proc_data            = '0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    idle();
    reset = 1'b1;
    tick();
    tick();

    // Requests during reset must not be granted.
    ic_req_valid = 1'b1; dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD;
    mem2proc_transaction_tag = 4'd3;
    #1;
    chk("rst_ic_acc", ic_req_accepted, 64'd0);
    chk("rst_dc_acc", dc_req_accepted, 64'd0);
    chk("rst_cmd", proc2mem_command, 64'(MEM_NONE));
    tick();
    chk("rst_starve", dut.starve_cnt_q, 64'd0);
    chk("rst_outst", dut.outstanding, 64'd0);
    reset = 1'b0;
    idle();

    // Both valid: dcache wins with tag 3, icache starves by one.
    ic_req_valid = 1'b1; ic_req_addr = 32'h1000;
    dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'h2000;
    mem2proc_transaction_tag = 4'd3;
    #1;
    chk("c1_dc_acc", dc_req_accepted, 64'd1);
    chk("c1_dc_tag", dc_req_tag, 64'd3);
    chk("c1_ic_acc", ic_req_accepted, 64'd0);
    chk("c1_ic_tag", ic_req_tag, 64'd0);
    chk("c1_cmd", proc2mem_command, 64'(MEM_LOAD));
    chk("c1_addr", proc2mem_addr, 64'h2000);
    tick();
    chk("c1_starve", dut.starve_cnt_q, 64'd1);
    chk("c1_outst", dut.outstanding, 64'd1);
    chk("c1_valid3", dut.u_table.valid_q[3], 64'd1);
    chk("c1_owner3", dut.u_table.owner_q[3], 64'(OWNER_DCACHE));

    // Three more dcache stores keep the icache waiting.
    dc_req_cmd = MEM_STORE; dc_req_data = 64'h1111; mem2proc_transaction_tag = 4'd7;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("starve_dc_acc", dc_req_accepted, 64'd1);
      chk("starve_ic_acc", ic_req_accepted, 64'd0);
      tick();
    end
    chk("starve_cnt4", dut.starve_cnt_q, 64'd4);
    chk("store_not_recorded", dut.outstanding, 64'd1);

    // Fifth cycle: starved icache takes the slot with tag 5.
    mem2proc_transaction_tag = 4'd5;
    #1;
    chk("c5_ic_acc", ic_req_accepted, 64'd1);
    chk("c5_ic_tag", ic_req_tag, 64'd5);
    chk("c5_dc_acc", dc_req_accepted, 64'd0);
    chk("c5_dc_tag", dc_req_tag, 64'd0);
    chk("c5_cmd", proc2mem_command, 64'(MEM_LOAD));
    chk("c5_addr", proc2mem_addr, 64'h1000);
    chk("c5_data", proc2mem_data, 64'd0);
    tick();
    chk("c5_starve", dut.starve_cnt_q, 64'd0);
    chk("c5_outst", dut.outstanding, 64'd2);
    chk("c5_owner5", dut.u_table.owner_q[5], 64'(OWNER_ICACHE));
    idle();

    // Idle, then command-only cycle shows nothing driven.
    #1;
    chk("idle_cmd", proc2mem_command, 64'(MEM_NONE));
    for (int i = 0; i < 9; i++) tick();

    // Tag 5 data returns to the icache.
    mem2proc_data_tag = 4'd5; mem2proc_data = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk("ret5_ic", ic_return_valid, 64'd1);
    chk("ret5_dc", dc_return_valid, 64'd0);
    chk("ret5_tag", return_tag, 64'd5);
    chk("ret5_data", return_data, 64'hDEAD_BEEF_0123_4567);
    tick();
    chk("ret5_cleared", dut.u_table.valid_q[5], 64'd0);
    chk("ret5_outst", dut.outstanding, 64'd1);

    // Unknown tag is ignored but still passed through.
    mem2proc_data_tag = 4'd9; mem2proc_data = 64'h99;
    #1;
    chk("unk_ic", ic_return_valid, 64'd0);
    chk("unk_dc", dc_return_valid, 64'd0);
    chk("unk_tag", return_tag, 64'd9);
    chk("unk_data", return_data, 64'h99);
    tick();
    chk("unk_outst", dut.outstanding, 64'd1);

    // Tag 3 data returns to the dcache.
    mem2proc_data_tag = 4'd3;
    #1;
    chk("ret3_dc", dc_return_valid, 64'd1);
    chk("ret3_ic", ic_return_valid, 64'd0);
    tick();
    chk("ret3_outst", dut.outstanding, 64'd0);
    idle();

    // Memory rejects a dcache load.
    dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'h3000;
    #1;
    chk("rej_dc_acc", dc_req_accepted, 64'd0);
    chk("rej_dc_tag", dc_req_tag, 64'd0);
    chk("rej_cmd", proc2mem_command, 64'(MEM_LOAD));
    tick();
    chk("rej_outst", dut.outstanding, 64'd0);
    idle();

    // Icache owns tag 2, then return and reissue of tag 2 collide.
    ic_req_valid = 1'b1; ic_req_addr = 32'h4000; mem2proc_transaction_tag = 4'd2;
    tick();
    idle();
    chk("t2_outst", dut.outstanding, 64'd1);
    dc_req_valid = 1'b1; dc_req_cmd = MEM_LOAD; dc_req_addr = 32'h5000;
    mem2proc_transaction_tag = 4'd2; mem2proc_data_tag = 4'd2; mem2proc_data = 64'h22;
    #1;
    chk("swap_ic_ret", ic_return_valid, 64'd1);
    chk("swap_dc_ret", dc_return_valid, 64'd0);
    chk("swap_dc_acc", dc_req_accepted, 64'd1);
    tick();
    mem2proc_data_tag = '0;
    chk("swap_valid2", dut.u_table.valid_q[2], 64'd1);
    chk("swap_owner2", dut.u_table.owner_q[2], 64'(OWNER_DCACHE));
    chk("swap_outst", dut.outstanding, 64'd1);

    // Fill every remaining tag with dcache loads.
    for (int t = 1; t <= 15; t++) begin
      if (t != 2) begin
        mem2proc_transaction_tag = MEM_TAG'(t);
        tick();
      end
    end
    chk("full_outst", dut.outstanding, 64'd15);

    // Full: a store still goes, the icache load does not.
    ic_req_valid = 1'b1; dc_req_cmd = MEM_STORE; dc_req_data = 64'hCAFE;
    mem2proc_transaction_tag = 4'd8;
    #1;
    chk("full_st_acc", dc_req_accepted, 64'd1);
    chk("full_st_cmd", proc2mem_command, 64'(MEM_STORE));
    chk("full_st_data", proc2mem_data, 64'hCAFE);
    chk("full_st_ic", ic_req_accepted, 64'd0);
    tick();
    chk("full_st_outst", dut.outstanding, 64'd15);

    // Full: a dcache load blocks and the icache may not steal the slot.
    dc_req_cmd = MEM_LOAD;
    #1;
    chk("full_ld_cmd", proc2mem_command, 64'(MEM_NONE));
    chk("full_ld_dc", dc_req_accepted, 64'd0);
    chk("full_ld_ic", ic_req_accepted, 64'd0);
    tick();
    idle();

    // Reset with loads in flight discards ownership.
    reset = 1'b1; mem2proc_data_tag = 4'd3;
    #1;
    chk("rst_ret_dc", dc_return_valid, 64'd0);
    tick();
    reset = 1'b0; mem2proc_data_tag = 4'd1;
    #1;
    chk("post_rst_ic", ic_return_valid, 64'd0);
    chk("post_rst_dc", dc_return_valid, 64'd0);
    chk("post_rst_outst", dut.outstanding, 64'd0);
    tick();
    chk("post_rst_outst2", dut.outstanding, 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles the icache may be refused before it gets priority.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default `NUM_MEM_TAGS: cap on in-flight loads.
REQ-003 SHALL have ports, in this order:
- clock  input  1  clock
- reset  input  1  synchronous, active-high reset
- ic_req_valid  input  1  icache load request
- ic_req_addr  input  ADDR  icache line address
- ic_req_accepted  output  1  icache request issued this cycle
- ic_req_tag  output  MEM_TAG  tag given to the accepted icache request
- dc_req_valid  input  1  dcache request
- dc_req_cmd  input  MEM_COMMAND  MEM_LOAD or MEM_STORE
- dc_req_addr  input  ADDR  dcache address
- dc_req_data  input  MEM_BLOCK  store data
- dc_req_accepted  output  1  dcache request issued this cycle
- dc_req_tag  output  MEM_TAG  tag given to the accepted dcache request
- proc2mem_command  output  MEM_COMMAND  command to memory
- proc2mem_addr  output  ADDR  address to memory
- proc2mem_data  output  MEM_BLOCK  store data to memory
- mem2proc_transaction_tag  input  MEM_TAG  same-cycle response; 0 means rejected
- mem2proc_data_tag  input  MEM_TAG  tag of returning data; 0 means none
- mem2proc_data  input  MEM_BLOCK  returning data
- ic_return_valid  output  1  returning data belongs to the icache
- dc_return_valid  output  1  returning data belongs to the dcache
- return_tag  output  MEM_TAG  tag of the returning data
- return_data  output  MEM_BLOCK  mem2proc_data, passed through unchanged

Function
REQ-004 SHALL drive at most one request to memory per cycle; with no grant, proc2mem_command SHALL be MEM_NONE and addr/data SHALL be 0.
REQ-005 SHALL give the dcache priority, except when starve_cnt == STARVE_LIMIT and ic_req_valid is high; then the icache SHALL win.
REQ-006 starve_cnt SHALL increment (saturating at STARVE_LIMIT) each cycle ic_req_valid is high and ic_req_accepted is low, and SHALL clear when ic_req_accepted is high or ic_req_valid is low.
REQ-007 Loads SHALL be blocked (no grant to any load requester) while outstanding == MAX_OUTSTANDING; a dcache store SHALL still be granted.
REQ-008 In that blocked case, if the dcache request is a load, the icache SHALL NOT take the slot.
REQ-009 The winner's *_req_accepted SHALL be combinational and equal (mem2proc_transaction_tag != 0); *_req_tag SHALL equal mem2proc_transaction_tag; the loser SHALL see accepted=0 and tag=0.
REQ-010 An accepted load SHALL set table[tag] = {valid, owner} at the next clock edge and increment outstanding; an accepted store SHALL NOT be recorded.
REQ-011 When mem2proc_data_tag != 0 and table[tag].valid is set, the owner's return_valid SHALL be 1 in the same cycle; the entry SHALL clear and outstanding SHALL decrement at the next edge.
REQ-012 A return with an unknown or invalid tag SHALL assert neither return_valid and SHALL NOT change state.
REQ-013 return_tag SHALL equal mem2proc_data_tag, and return_data SHALL equal mem2proc_data, unconditionally.
REQ-014 If a return and a new accepted load occur in the same cycle:
- outstanding SHALL stay unchanged;
- if they use the same tag, the set SHALL win over the clear.
REQ-015 A rejected request (transaction tag 0) SHALL cause no table change; the requester retries by holding its valid signal.

Reset
REQ-016 While reset is high:
- all table entries invalid; outstanding = 0; starve_cnt = 0;
- accepted and return_valid outputs 0; proc2mem_command = MEM_NONE.
REQ-017 Reset asserted mid-transaction SHALL discard all in-flight ownership; later returns of those tags SHALL be ignored per REQ-012.

Structure
REQ-018 The shared package SHALL hold:
- MEM_OWNER enum {OWNER_ICACHE, OWNER_DCACHE};
- constants ARB_STARVE_LIMIT and ARB_MAX_OUTSTANDING;
- the MEM_TAG, MEM_COMMAND, MEM_BLOCK and ADDR types, already in sys_defs.
REQ-019 The tag ownership table SHALL be one sub-module, mem_tag_table, with one set port, one lookup/clear port, and an outstanding count output.

Verification
REQ-020 Both requesters valid, memory grants tag 3 -> dcache accepted with tag 3; icache accepted 0; starve_cnt = 1.
REQ-021 Both requesters valid for 4 cycles with STARVE_LIMIT = 4 -> on cycle 5 the icache is accepted; starve_cnt then reads 0.
REQ-022 Icache load gets tag 5; 10 cycles later data_tag = 5 -> ic_return_valid = 1 with matching data; dc_return_valid = 0; table[5] cleared.
REQ-023 Fill to MAX_OUTSTANDING loads, then dcache store plus icache load requested -> store issued; icache not accepted; outstanding unchanged.
REQ-024 In one cycle, data returns on tag 2 while a new dcache load is granted tag 2 -> return routed to the old owner; table[2] = dcache; outstanding unchanged.
REQ-025 Reset pulse with 3 loads outstanding, then data_tag = 1 -> neither return_valid asserted.
